// File: rtl/exponent.sv
// Exponent field-select codes shared by the result-assembly stage.
package exponent;
   typedef enum logic [1:0] {
      EXP_COMPUTE,
      EXP_A,
      EXP_B,
      EXP_ONES
   } exponent_select;
endpackage

// File: rtl/fraction_lsbs.sv
// Fraction LSBs field-select codes shared by the result-assembly stage.
package fraction_lsbs;
   typedef enum logic [1:0] {
      FRAC_LSBS_COMPUTE,
      FRAC_LSBS_A,
      FRAC_LSBS_B,
      FRAC_LSBS_ZERO
   } fraction_lsbs_select;
endpackage

// File: rtl/fraction_msb.sv
// Fraction MSB field-select codes; FRAC_MSB_ONE builds a quiet NaN.
package fraction_msb;
   typedef enum logic [1:0] {
      FRAC_MSB_COMPUTE,
      FRAC_MSB_A,
      FRAC_MSB_B,
      FRAC_MSB_ONE
   } fraction_msb_select;
endpackage

// File: rtl/result_arbiter_pkg.sv
// Shared types for the result arbiter: request bundle, FSM states, source codes.
package result_arbiter_pkg;
   typedef struct packed {
      sign::sign_select                   sign_sel;
      exponent::exponent_select           exponent_sel;
      fraction_msb::fraction_msb_select   fraction_msb_sel;
      fraction_lsbs::fraction_lsbs_select fraction_lsbs_sel;
      logic                               sign_a;
      logic                               sign_b;
      logic [7:0]                         exponent_a;
      logic [7:0]                         exponent_b;
      logic [23:0]                        fraction_a;
      logic [23:0]                        fraction_b;
      logic                               result_sign;
      logic [9:0]                         result_exponent;
      logic [31:0]                        result_fraction;
   } result_request_t;

   typedef enum logic {
      EMPTY,
      FULL
   } arb_state;

   localparam logic SRC_PIPE = 1'b0;
   localparam logic SRC_ITER = 1'b1;
endpackage

// File: rtl/sign.sv
// Sign field-select codes shared by the result-assembly stage.
package sign;
   typedef enum logic [1:0] {
      SIGN_COMPUTE,
      SIGN_A,
      SIGN_B,
      SIGN_ZERO
   } sign_select;
endpackage

// File: rtl/result_arbiter_grant.sv
// Grant selection between pipelined and iterative requesters.
// RESULT_ARB_FAIRNESS_EN adds the starvation counter that forces an iterative win.
module result_arbiter_grant #(
   parameter int STARVE_LIMIT = 4
) (
`ifdef RESULT_ARB_FAIRNESS_EN
   input  logic clk,
   input  logic reset,
   input  logic flush,
`endif
   input  logic can_accept,
   input  logic pipe_valid,
   input  logic iter_valid,
   output logic pipe_ready,
   output logic iter_ready
);
   logic pipe_win;
   logic iter_win;

   if (STARVE_LIMIT < 1 || STARVE_LIMIT > 15) begin : g_bad_limit
      $error("result_arbiter_grant: STARVE_LIMIT must be within 1..15");
   end

`ifdef RESULT_ARB_FAIRNESS_EN
   logic [3:0] starve_count;
   logic       force_iter;

   assign force_iter = (starve_count == 4'(STARVE_LIMIT));

   // Counts consecutive accepting cycles in which a waiting iterative request loses.
   always_ff @(posedge clk) begin
      if (reset) begin
         starve_count <= '0;
      end else if (flush || !iter_valid) begin
         starve_count <= '0;
      end else if (can_accept) begin
         if (iter_win) begin
            starve_count <= '0;
         end else if (!force_iter) begin
            starve_count <= starve_count + 4'd1;
         end
      end
   end
`endif

   always_comb begin
      pipe_win = pipe_valid;
      iter_win = iter_valid && !pipe_valid;
`ifdef RESULT_ARB_FAIRNESS_EN
      if (pipe_valid && iter_valid && force_iter) begin
         pipe_win = 1'b0;
         iter_win = 1'b1;
      end
`endif
   end

   assign pipe_ready = can_accept && pipe_win;
   assign iter_ready = can_accept && iter_win;
endmodule

// File: rtl/result_selecter.sv
// Packs a single-precision result from the selected fields of a request bundle.
// Raw results carry the hidden bit at [30] (or [31] after carry) and are rounded to nearest-even.
module result_selecter
   import result_arbiter_pkg::*;
(
   input  result_request_t request,
   output logic [31:0]     result
);
   logic [29:0] norm;
   logic [9:0]  norm_exp;
   logic        round_up;
   logic [23:0] rounded;
   logic [9:0]  final_exp;
   logic [7:0]  comp_exp;
   logic [22:0] comp_frac;
   logic        res_sign;
   logic [7:0]  res_exp;
   logic        res_msb;
   logic [21:0] res_lsbs;

   // A set bit 31 means the raw significand overflowed; shift right, folding bit 0 into sticky.
   always_comb begin
      norm      = request.result_fraction[31] ?
                  {request.result_fraction[30:2], request.result_fraction[1] | request.result_fraction[0]} :
                  request.result_fraction[29:0];
      norm_exp  = request.result_exponent + {9'b0, request.result_fraction[31]};
      round_up  = norm[6] & (norm[7] | (|norm[5:0]));
      rounded   = {1'b0, norm[29:7]} + {23'b0, round_up};
      final_exp = norm_exp + {9'b0, rounded[23]};
      comp_exp  = final_exp[7:0];
      comp_frac = rounded[22:0];
      if (final_exp[9]) begin
         comp_exp  = 8'h00;
         comp_frac = '0;
      end else if (final_exp[8] || (&final_exp[7:0])) begin
         comp_exp  = 8'hFF;
         comp_frac = '0;
      end
   end

   // Operands are held unpacked; a clear hidden bit marks a denormal whose packed exponent is 0.
   always_comb begin
      res_sign = request.result_sign;
      res_exp  = comp_exp;
      res_msb  = comp_frac[22];
      res_lsbs = comp_frac[21:0];
      case (request.sign_sel)
         sign::SIGN_COMPUTE: res_sign = request.result_sign;
         sign::SIGN_A:       res_sign = request.sign_a;
         sign::SIGN_B:       res_sign = request.sign_b;
         sign::SIGN_ZERO:    res_sign = 1'b0;
      endcase
      case (request.exponent_sel)
         exponent::EXP_COMPUTE: res_exp = comp_exp;
         exponent::EXP_A:       res_exp = request.fraction_a[23] ? request.exponent_a : 8'h00;
         exponent::EXP_B:       res_exp = request.fraction_b[23] ? request.exponent_b : 8'h00;
         exponent::EXP_ONES:    res_exp = 8'hFF;
      endcase
      case (request.fraction_msb_sel)
         fraction_msb::FRAC_MSB_COMPUTE: res_msb = comp_frac[22];
         fraction_msb::FRAC_MSB_A:       res_msb = request.fraction_a[22];
         fraction_msb::FRAC_MSB_B:       res_msb = request.fraction_b[22];
         fraction_msb::FRAC_MSB_ONE:     res_msb = 1'b1;
      endcase
      case (request.fraction_lsbs_sel)
         fraction_lsbs::FRAC_LSBS_COMPUTE: res_lsbs = comp_frac[21:0];
         fraction_lsbs::FRAC_LSBS_A:       res_lsbs = request.fraction_a[21:0];
         fraction_lsbs::FRAC_LSBS_B:       res_lsbs = request.fraction_b[21:0];
         fraction_lsbs::FRAC_LSBS_ZERO:    res_lsbs = '0;
      endcase
   end

   assign result = {res_sign, res_exp, res_msb, res_lsbs};
endmodule

// File: rtl/result_arbiter.sv
// Arbitrates the shared result-assembly stage between the pipelined and iterative units.
// Define RESULT_ARB_FAIRNESS_EN to enable starvation protection for the iterative unit.
module result_arbiter
   import result_arbiter_pkg::*;
#(
   parameter int STARVE_LIMIT = 4
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            pipe_valid,
   output logic            pipe_ready,
   input  result_request_t pipe_request,
   input  logic            iter_valid,
   output logic            iter_ready,
   input  result_request_t iter_request,
   input  logic            flush,
   output result_request_t sel_request,
   output logic            out_valid,
   input  logic            out_ready,
   output logic            out_source,
   output logic [31:0]     result
);
   arb_state state;
   arb_state next_state;
   logic     can_accept;
   logic     grant;

   // Readies stay low while reset is asserted so nothing is handed over mid-reset.
   assign can_accept = ((state == EMPTY) || out_ready) && !flush && !reset;
   assign grant      = pipe_ready || iter_ready;

   result_arbiter_grant #(
      .STARVE_LIMIT(STARVE_LIMIT)
   ) u_grant (
`ifdef RESULT_ARB_FAIRNESS_EN
      .clk        (clk),
      .reset      (reset),
      .flush      (flush),
`endif
      .can_accept (can_accept),
      .pipe_valid (pipe_valid),
      .iter_valid (iter_valid),
      .pipe_ready (pipe_ready),
      .iter_ready (iter_ready)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= EMPTY;
      end else begin
         state <= next_state;
      end
   end

   always_comb begin
      next_state = state;
      if (flush) begin
         next_state = EMPTY;
      end else if (grant) begin
         next_state = FULL;
      end else if (out_ready) begin
         next_state = EMPTY;
      end
   end

   // The held bundle only changes on a grant; after draining it is stale but retained.
   always_ff @(posedge clk) begin
      if (reset) begin
         sel_request <= '0;
         out_source  <= SRC_PIPE;
      end else if (iter_ready) begin
         sel_request <= iter_request;
         out_source  <= SRC_ITER;
      end else if (pipe_ready) begin
         sel_request <= pipe_request;
         out_source  <= SRC_PIPE;
      end
   end

   assign out_valid = (state == FULL);

   result_selecter u_selecter (
      .request (sel_request),
      .result  (result)
   );
endmodule
